// File: rtl/pulse_stretch_fsm.sv
// Stretches single-clock event pulses on x into a HOLD_CYCLES-long level on y,
// with a GAP_CYCLES low gap, a one-deep event queue and a dropped-event strobe.
module pulse_stretch_fsm #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int RETRIGGER   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic y,
  output logic busy,
  output logic dropped
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_HG > 2) ? MAX_HG : 2;
  localparam int CW      = $clog2(MAX_ALL);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pending;
  logic          r_xq;

  logic          w_event;
  logic          w_tc;
  logic [1:0]    w_nextState;
  logic [CW-1:0] w_nextCnt;
  logic          w_nextPending;
  logic          w_drop;
  logic          w_sy;

  assign w_event = x & ~r_xq;
  assign w_tc    = (r_cnt == '0);
  assign w_sy    = (r_state == ST_HOLD);

  // A terminal-count event is folded into the queue/reload decision, so it is
  // only lost when an earlier event is already waiting.
  always_comb begin
    w_nextState   = r_state;
    w_nextCnt     = r_cnt;
    w_nextPending = r_pending;
    w_drop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_event) begin
          w_nextState = ST_HOLD;
          w_nextCnt   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (w_event && (RETRIGGER != 0)) begin
          w_nextCnt = HOLD_LOAD;
        end else begin
          if (w_event) begin
            w_nextPending = 1'b1;
            w_drop        = r_pending;
          end
          if (w_tc) begin
            if (GAP_CYCLES > 0) begin
              w_nextState = ST_GAP;
              w_nextCnt   = GAP_LOAD;
            end else if (r_pending || w_event) begin
              w_nextCnt     = HOLD_LOAD;
              w_nextPending = 1'b0;
            end else begin
              w_nextState = ST_IDLE;
            end
          end else begin
            w_nextCnt = r_cnt - CW'(1);
          end
        end
      end
      ST_GAP: begin
        if (w_event) begin
          w_nextPending = 1'b1;
          w_drop        = r_pending;
        end
        if (w_tc) begin
          if (r_pending || w_event) begin
            w_nextState   = ST_HOLD;
            w_nextCnt     = HOLD_LOAD;
            w_nextPending = 1'b0;
          end else begin
            w_nextState = ST_IDLE;
          end
        end else begin
          w_nextCnt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_nextState   = ST_IDLE;
        w_nextCnt     = '0;
        w_nextPending = 1'b0;
      end
    endcase
  end

  // x_q resets high so a level already present at release is not an event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_xq      <= 1'b1;
      y         <= 1'b0;
      busy      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_nextCnt;
      r_pending <= w_nextPending;
      r_xq      <= x;
      y         <= w_sy;
      busy      <= (r_state != ST_IDLE);
      dropped   <= w_drop;
    end
  end

endmodule

// File: tb/tb_pulse_stretch_fsm.sv
// Drives three pulse_stretch_fsm variants (queued, retrigger, no-gap) with shared
// stimulus and scores every output cycle against a per-variant timeline model.
module tb_pulse_stretch_fsm;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       x   = 1'b0;
  logic [2:0] y;
  logic [2:0] busy;
  logic [2:0] dropped;

  always #5 clk = ~clk;

  pulse_stretch_fsm #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(2), .RETRIGGER(0)) dutQueued (
    .clk(clk), .rst(rst), .x(x), .y(y[0]), .busy(busy[0]), .dropped(dropped[0]));
  pulse_stretch_fsm #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(2), .RETRIGGER(1)) dutRetrig (
    .clk(clk), .rst(rst), .x(x), .y(y[1]), .busy(busy[1]), .dropped(dropped[1]));
  pulse_stretch_fsm #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .RETRIGGER(0)) dutNoGap (
    .clk(clk), .rst(rst), .x(x), .y(y[2]), .busy(busy[2]), .dropped(dropped[2]));

  typedef struct packed {
    logic [2:0] y;
    logic [2:0] busy;
    logic [2:0] drop;
  } expT;

  expT expQ[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cycle      = 0;

  int  cfgGap[3]    = '{2, 2, 0};
  bit  cfgRetrig[3] = '{1'b0, 1'b1, 1'b0};
  int  holdLeft[3];
  int  gapLeft[3];
  bit  queued[3];
  bit  prevX;

  always @(posedge clk) cycle++;

  // Timeline model: remaining high/low clocks plus a one-deep waiting event.
  task automatic modelReset();
    prevX = 1'b1;
    for (int i = 0; i < 3; i++) begin
      holdLeft[i] = 0;
      gapLeft[i]  = 0;
      queued[i]   = 1'b0;
    end
  endtask

  task automatic modelStep(output expT e);
    bit ev;
    ev    = x & ~prevX;
    prevX = x;
    e     = '0;
    for (int i = 0; i < 3; i++) begin
      e.y[i]    = (holdLeft[i] > 0);
      e.busy[i] = (holdLeft[i] > 0) || (gapLeft[i] > 0);
      if (holdLeft[i] > 0) begin
        if (ev && cfgRetrig[i]) begin
          holdLeft[i] = HOLD;
        end else begin
          if (ev) begin
            e.drop[i] = queued[i];
            queued[i] = 1'b1;
          end
          holdLeft[i]--;
          if (holdLeft[i] == 0) begin
            if (cfgGap[i] > 0) begin
              gapLeft[i] = cfgGap[i];
            end else if (queued[i]) begin
              holdLeft[i] = HOLD;
              queued[i]   = 1'b0;
            end
          end
        end
      end else if (gapLeft[i] > 0) begin
        if (ev) begin
          e.drop[i] = queued[i];
          queued[i] = 1'b1;
        end
        gapLeft[i]--;
        if (gapLeft[i] == 0 && queued[i]) begin
          holdLeft[i] = HOLD;
          queued[i]   = 1'b0;
        end
      end else if (ev) begin
        holdLeft[i] = HOLD;
      end
    end
  endtask

  task automatic compareBit(string name, logic act, logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cycle, act, exp);
    end
  endtask

  task automatic checkOutput(expT e);
    for (int i = 0; i < 3; i++) begin
      compareBit($sformatf("y[%0d]", i), y[i], e.y[i]);
      compareBit($sformatf("busy[%0d]", i), busy[i], e.busy[i]);
      compareBit($sformatf("dropped[%0d]", i), dropped[i], e.drop[i]);
    end
  endtask

  // x holds val for n sampled edges; each edge pushes the model's prediction.
  task automatic applyStimulus(bit val, int n);
    expT e;
    repeat (n) begin
      @(posedge clk);
      if (rst) begin
        modelStep(e);
        expQ.push_back(e);
      end
      #1 x = val;
    end
  endtask

  task automatic asyncReset(bit xDuring);
    @(posedge clk);
    #2 rst = 1'b0;
    x = xDuring;
    expQ.delete();
    modelReset();
    #1 checkOutput('0);
    repeat (2) @(negedge clk);
    checkOutput('0);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    rst = 1'b0;
    x   = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput('0);
    rst = 1'b1;

    applyStimulus(0, 9);  applyStimulus(1, 1);  applyStimulus(0, 20);
    applyStimulus(1, 20); applyStimulus(0, 20);
    applyStimulus(1, 1);  applyStimulus(0, 1);  applyStimulus(1, 1);  applyStimulus(0, 20);
    applyStimulus(1, 1);  applyStimulus(0, 1);  applyStimulus(1, 1);  applyStimulus(0, 1);
    applyStimulus(1, 1);  applyStimulus(0, 20);
    applyStimulus(1, 1);  applyStimulus(0, 2);  applyStimulus(1, 1);  applyStimulus(0, 20);

    asyncReset(1'b1);
    applyStimulus(1, 10); applyStimulus(0, 20);

    applyStimulus(1, 1);  applyStimulus(0, 1);  applyStimulus(1, 1);  applyStimulus(0, 1);
    asyncReset(1'b0);
    applyStimulus(0, 20);

    for (int k = 0; k < 600; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
      if (k % 150 == 149) asyncReset(1'($urandom_range(0, 1)));
    end

    applyStimulus(0, 20);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
